// File: rtl/txt_pkg.sv
// Shared types, default geometry and the ring-offset helper for the text frame buffer.
package txt_pkg;

    localparam int         TXT_COLS = 40;
    localparam int         TXT_ROWS = 24;
    localparam logic [7:0] TXT_FILL = 8'hA0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SCROLL = 2'd2
    } state_t;

    // Both operands are below depth, so a single conditional subtract replaces a modulo.
    function automatic int unsigned wrap_add(input int unsigned adr,
                                             input int unsigned base,
                                             input int unsigned depth);
        int unsigned sum;
        sum = adr + base;
        return (sum >= depth) ? (sum - depth) : sum;
    endfunction

endpackage

// File: rtl/txt_ram.sv
// Simple dual-port character RAM: one write port, one registered read port, old data on collision.
module txt_ram #(
    parameter int DEPTH = 960,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/txt_framebuffer.sv
// Character-cell frame buffer with ring-offset line scroll and a block clear engine.
// Optional blinking cursor (inverse-video bit toggle) is built when TXT_CURSOR_EN is defined.
module txt_framebuffer
    import txt_pkg::*;
#(
    parameter int            COLS      = TXT_COLS,
    parameter int            ROWS      = TXT_ROWS,
    parameter int            DW        = 8,
    parameter logic [DW-1:0] FILL_CHAR = DW'(TXT_FILL),
    parameter int            BLINK_DIV = 12_500_000
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    input  logic [15:0]   cpu_adr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_wr,
    input  logic          cpu_clear,
    input  logic          cpu_scroll,
    output logic          cpu_ready,
    input  logic [15:0]   vdp_adr,
    output logic [DW-1:0] txt,
    input  logic [15:0]   cur_adr,
    output state_t        dbg_state
);

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW-1:0] LAST_CELL = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_BASE = AW'(DEPTH - COLS);
    localparam logic [AW-1:0] LAST_COL  = AW'(COLS - 1);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_base, w_base_nxt;
    logic [AW-1:0] r_cnt, w_cnt_nxt;
    logic          r_fill_sel;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [AW-1:0] w_cpu_phys;
    logic [AW-1:0] w_row_phys;
    logic [AW-1:0] w_rd_phys;
    logic          w_cpu_in_range;
    logic          w_vdp_in_range;
    logic [DW-1:0] w_ram_q;
    logic [DW-1:0] w_raw;

    assign w_cpu_in_range = (32'(cpu_adr) < 32'(DEPTH));
    assign w_vdp_in_range = (32'(vdp_adr) < 32'(DEPTH));
    assign w_cpu_phys     = AW'(wrap_add(32'(cpu_adr), 32'(r_base), DEPTH));
    assign w_rd_phys      = AW'(wrap_add(32'(vdp_adr), 32'(r_base), DEPTH));
    // r_base already points past the old top row, so the new bottom row reuses its cells.
    assign w_row_phys     = AW'(wrap_add(32'(DEPTH - COLS) + 32'(r_cnt), 32'(r_base), DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_waddr     = w_cpu_phys;
        w_wdata     = cpu_wdata;
        case (r_state)
            IDLE: begin
                if (cpu_clear) begin
                    w_state_nxt = CLEAR;
                    w_base_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else if (cpu_scroll) begin
                    w_state_nxt = SCROLL;
                    w_base_nxt  = (r_base == LAST_BASE) ? '0 : r_base + COLS_A;
                    w_cnt_nxt   = '0;
                end else if (cpu_wr && w_cpu_in_range) begin
                    w_we = 1'b1;
                end
            end
            CLEAR: begin
                w_we      = 1'b1;
                w_waddr   = r_cnt;
                w_wdata   = FILL_CHAR;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_CELL) begin
                    w_state_nxt = IDLE;
                end
            end
            SCROLL: begin
                w_we      = 1'b1;
                w_waddr   = w_row_phys;
                w_wdata   = FILL_CHAR;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_COL) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // A reset cycle must not complete a pending fill write.
        if (!RESET_N) begin
            w_we = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_cnt      <= '0;
            r_fill_sel <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_base     <= w_base_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fill_sel <= ~w_vdp_in_range;
        end
    end

    txt_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .i_clk   (CLOCK_50),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_phys),
        .o_rdata (w_ram_q)
    );

    assign w_raw     = r_fill_sel ? FILL_CHAR : w_ram_q;
    assign cpu_ready = (r_state == IDLE);
    assign dbg_state = r_state;

`ifdef TXT_CURSOR_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic          r_inv;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
            r_inv <= r_phase && (vdp_adr == cur_adr);
        end
    end

    assign txt = w_raw ^ {r_inv, {(DW-1){1'b0}}};
`else
    localparam int unused_blink_div = BLINK_DIV;
    logic w_unused_cur;

    assign w_unused_cur = ^cur_adr;
    assign txt          = w_raw;
`endif

endmodule
